// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - load/store front end for a word-only data memory
// Sub-word stores are read-modify-write; sub-word loads are lane-selected and extended.
module mem_access_unit #(
  parameter int MEM_AW      = 10,
  parameter bit CHECK_RANGE = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RD     = 3'd1,
    S_LD_RSP = 3'd2,
    S_WR     = 3'd3,
    S_ACK    = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        err_q, err_d;

  logic        accept;
  logic        req_err;
  logic        out_of_range;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] ld_data;
  logic [31:0] merged;

  assign accept       = (state_q == S_IDLE) && req_valid;
  assign out_of_range = CHECK_RANGE && ((req_addr >> (MEM_AW + 2)) != 32'd0);
  assign req_err      = (req_size == 2'b11)
                     || (req_size == 2'b01 && req_addr[0])
                     || (req_size == 2'b10 && req_addr[1:0] != 2'b00)
                     || out_of_range;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  // Request capture happens only on the accept edge; fields then hold for the whole transaction.
  always_comb begin
    we_d    = we_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    if (accept) begin
      we_d    = req_we;
      size_d  = req_size;
      uns_d   = req_unsigned;
      addr_d  = req_addr;
      wdata_d = req_wdata;
      err_d   = req_err;
    end
  end

  always_comb begin
    lane_b = 8'd0;
    case (addr_q[1:0])
      2'd0: lane_b = mem_rdata[7:0];
      2'd1: lane_b = mem_rdata[15:8];
      2'd2: lane_b = mem_rdata[23:16];
      2'd3: lane_b = mem_rdata[31:24];
      default: lane_b = 8'd0;
    endcase
    lane_h = addr_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (size_q)
      2'b00:   ld_data = {{24{~uns_q & lane_b[7]}}, lane_b};
      2'b01:   ld_data = {{16{~uns_q & lane_h[15]}}, lane_h};
      default: ld_data = mem_rdata;
    endcase
  end

  always_comb begin
    merged = mem_rdata;
    case (size_q)
      2'b00: begin
        case (addr_q[1:0])
          2'd0: merged[7:0]   = wdata_q[7:0];
          2'd1: merged[15:8]  = wdata_q[7:0];
          2'd2: merged[23:16] = wdata_q[7:0];
          2'd3: merged[31:24] = wdata_q[7:0];
          default: merged = mem_rdata;
        endcase
      end
      2'b01: begin
        if (addr_q[1]) merged[31:16] = wdata_q[15:0];
        else           merged[15:0]  = wdata_q[15:0];
      end
      default: merged = wdata_q;
    endcase
  end

  assign mem_addr = {addr_q[31:2], 2'b00};

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_rdata = 32'd0;
    rsp_err   = 1'b0;
    mem_we    = 1'b0;
    mem_wdata = 32'd0;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_err)                           state_d = S_ACK;
          else if (req_we && req_size == 2'b10)  state_d = S_WR;
          else                                   state_d = S_RD;
        end
      end
      S_RD: state_d = we_q ? S_WR : S_LD_RSP;
      S_LD_RSP: begin
        rsp_valid = 1'b1;
        rsp_rdata = ld_data;
        state_d   = S_IDLE;
      end
      S_WR: begin
        mem_we    = 1'b1;
        mem_wdata = merged;
        state_d   = S_ACK;
      end
      S_ACK: begin
        rsp_valid = 1'b1;
        rsp_err   = err_q;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - scoreboard bench for mem_access_unit
// Directed scenarios followed by randomized traffic against a word-array reference model.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata = 32'd0;

  mem_access_unit #(.MEM_AW(10), .CHECK_RANGE(1'b1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] dmem [1024] = '{default: 32'd0};
  always @(posedge clk) begin
    if (mem_we) dmem[mem_addr[11:2]] <= mem_wdata;
    mem_rdata <= dmem[mem_addr[11:2]];
  end

  typedef struct {
    logic [31:0] rd;
    logic        err;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  logic [31:0] ref_mem [1024] = '{default: 32'd0};
  int checks = 0;
  int failures = 0;
  int exp_we = 0;
  int act_we = 0;
  int prev_acc = 0;
  int prev_lat = 0;
  bit back2back = 0;

  always @(negedge clk) begin
    if (rst) begin
      checks++;
      if (!mem_we && mem_wdata != 32'd0) begin
        failures++;
        $display("FAIL wdata_idle act=%h req=00000000", mem_wdata);
      end
      checks++;
      if (!rsp_valid && rsp_rdata != 32'd0) begin
        failures++;
        $display("FAIL rdata_idle act=%h req=00000000", rsp_rdata);
      end
      if (mem_we) begin
        act_we++;
        checks++;
        if (mem_addr[1:0] != 2'b00) begin
          failures++;
          $display("FAIL wr_align act=%h req=word-aligned", mem_addr);
        end
      end
      if (rsp_valid) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_rsp act=rsp_valid req=none cyc=%0d", cyc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (rsp_rdata !== e.rd || rsp_err !== e.err || cyc != e.cyc) begin
            failures++;
            $display("FAIL rsp act=%h/%0b@%0d req=%h/%0b@%0d",
                     rsp_rdata, rsp_err, cyc, e.rd, e.err, e.cyc);
          end
        end
      end
    end
  end

  task automatic model(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rd, output logic err, output int lat);
    int bytes, sh, idx;
    logic [31:0] mask, word;
    bytes = 1 << size;
    err = (size == 2'b11) || ((int'(addr[1:0]) % bytes) != 0) || (addr >= 32'h1000);
    rd = 32'd0;
    lat = 1;
    if (!err) begin
      idx  = int'(addr[11:2]);
      sh   = 8 * int'(addr[1:0]);
      mask = (bytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * bytes)) - 32'd1);
      word = ref_mem[idx];
      if (!we) begin
        rd = (word >> sh) & mask;
        if (!uns && bytes < 4 && rd[8 * bytes - 1]) rd = rd | ~mask;
        lat = 2;
      end else begin
        ref_mem[idx] = (word & ~(mask << sh)) | ((wdata & mask) << sh);
        exp_we++;
        lat = (bytes == 4) ? 2 : 3;
      end
    end
  endtask

  task automatic do_op(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input bit use_c, input logic [31:0] c_rd, input logic c_err);
    logic [31:0] rd;
    logic err;
    int lat, n, acc;
    exp_t e;
    model(we, size, uns, addr, wdata, rd, err, lat);
    if (use_c) begin
      rd  = c_rd;
      err = c_err;
    end
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready && n < 50);
    if (!req_ready) begin
      checks++; failures++;
      $display("FAIL accept_timeout act=req_ready0 req=req_ready1 addr=%h", addr);
      req_valid = 1'b0;
      back2back = 0;
      return;
    end
    acc = cyc + 1;
    e.rd = rd; e.err = err; e.cyc = cyc + lat;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (back2back) begin
      checks++;
      if (acc - prev_acc != prev_lat + 1) begin
        failures++;
        $display("FAIL accept_gap act=%0d req=%0d", acc - prev_acc, prev_lat + 1);
      end
    end
    prev_acc = acc;
    prev_lat = lat;
    back2back = 1;
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    back2back = 0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s act=%h req=%h", name, act, req);
    end
  endtask

  initial begin
    int n, bad;
    logic [31:0] a;
    #1;
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    @(negedge clk); rst = 1'b1;
    idle(2);

    do_op(1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 1, 32'd0, 1'b0);
    do_op(0, 2'b10, 0, 32'h10, 32'd0, 1, 32'hDEADBEEF, 1'b0);
    idle(1);
    do_op(1, 2'b10, 0, 32'h10, 32'h11223344, 1, 32'd0, 1'b0);
    do_op(1, 2'b00, 0, 32'h13, 32'h000000AA, 1, 32'd0, 1'b0);
    do_op(0, 2'b10, 0, 32'h10, 32'd0, 1, 32'hAA223344, 1'b0);
    do_op(0, 2'b00, 0, 32'h13, 32'd0, 1, 32'hFFFFFFAA, 1'b0);
    do_op(0, 2'b00, 1, 32'h13, 32'd0, 1, 32'h000000AA, 1'b0);
    do_op(1, 2'b10, 0, 32'h10, 32'h11223344, 1, 32'd0, 1'b0);
    do_op(1, 2'b01, 0, 32'h12, 32'h00008001, 1, 32'd0, 1'b0);
    do_op(0, 2'b10, 0, 32'h10, 32'd0, 1, 32'h80013344, 1'b0);
    do_op(0, 2'b01, 0, 32'h12, 32'd0, 1, 32'hFFFF8001, 1'b0);
    do_op(0, 2'b01, 1, 32'h10, 32'd0, 1, 32'h00003344, 1'b0);
    idle(2);
    do_op(0, 2'b10, 0, 32'h12, 32'd0, 1, 32'd0, 1'b1);
    do_op(1, 2'b01, 0, 32'h11, 32'hFFFF, 1, 32'd0, 1'b1);
    do_op(1, 2'b11, 0, 32'h14, 32'h1234, 1, 32'd0, 1'b1);
    do_op(0, 2'b10, 0, 32'h1000, 32'd0, 1, 32'd0, 1'b1);
    do_op(1, 2'b10, 0, 32'h8000_0010, 32'h5555, 1, 32'd0, 1'b1);
    idle(2);
    do_op(0, 2'b10, 0, 32'h10, 32'd0, 0, 32'd0, 1'b0);
    do_op(0, 2'b00, 1, 32'h11, 32'd0, 0, 32'd0, 1'b0);
    do_op(0, 2'b01, 0, 32'h12, 32'd0, 0, 32'd0, 1'b0);
    idle(3);

    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 32'h13; req_wdata = 32'h55;
    n = 0;
    do begin @(negedge clk); n++; end while (!req_ready && n < 20);
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!mem_we && n < 5);
    checks++;
    if (!mem_we) begin
      failures++;
      $display("FAIL abort_reach_wr act=mem_we0 req=mem_we1");
    end else begin
      exp_we++;
    end
    #2 rst = 1'b0;
    #1;
    chk("abort_mem_we", {31'd0, mem_we}, 32'd0);
    chk("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("abort_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk); rst = 1'b1;
    idle(2);
    do_op(0, 2'b10, 0, 32'h10, 32'd0, 0, 32'd0, 1'b0);

    for (int i = 0; i < 300; i++) begin
      a = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 9) == 0) a = a | (32'd1 << $urandom_range(12, 31));
      do_op(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), a, $urandom, 0, 32'd0, 1'b0);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(0, 3));
    end
    idle(1);

    n = 0;
    while (sb.size() != 0 && n < 20) begin @(posedge clk); n++; end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    chk("mem_we_cycles", 32'(act_we), 32'(exp_we));
    bad = 0;
    for (int i = 0; i < 1024; i++) if (dmem[i] !== ref_mem[i]) bad++;
    chk("mem_contents_bad_words", 32'(bad), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
